// File: rtl/pow_builder_if.sv
// Handshake bundle for pow_builder: index beat stream in, rebuilt word out.
interface pow_builder_if #(parameter int WIDTH = 8);
    localparam int IDX_W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] in_idx;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_mask;
    logic [IDX_W:0]   out_cnt;
    logic [IDX_W-1:0] out_top;
    logic             out_dup;

    modport master (
        output in_valid, in_idx, in_last, out_ready,
        input  in_ready, out_valid, out_mask, out_cnt, out_top, out_dup
    );
    modport slave (
        input  in_valid, in_idx, in_last, out_ready,
        output in_ready, out_valid, out_mask, out_cnt, out_top, out_dup
    );
endinterface

// File: rtl/pow_builder.sv
// Rebuilds a WIDTH-bit word from a burst of bit indices and presents it with popcount/top index.
// Optional duplicate-index detection is built when POW_BUILDER_DUP_CHK_EN is defined.
module pow_builder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    pow_builder_if.slave   bus
);
    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [IDX_W:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0] top_q, top_d;

    logic [WIDTH-1:0] onehot;
    logic [WIDTH-1:0] mask_nxt;
    logic [IDX_W:0]   cnt_c;
    logic [IDX_W-1:0] top_c;
    logic             accept;

    // Indices at or above WIDTH match no position and therefore set nothing.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < WIDTH; i++)
            onehot[i] = (bus.in_idx == IDX_W'(i));
    end

    assign mask_nxt = acc_q | onehot;

    always_comb begin
        cnt_c = '0;
        top_c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_c = cnt_c + {{IDX_W{1'b0}}, mask_nxt[i]};
            if (mask_nxt[i]) top_c = IDX_W'(i);
        end
    end

    assign accept = bus.in_valid && (state_q != EMIT);

`ifdef POW_BUILDER_DUP_CHK_EN
    logic dacc_q, dacc_d;
    logic dup_q, dup_d;
    logic hit;

    assign hit = |(acc_q & onehot);
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        top_d   = top_q;
`ifdef POW_BUILDER_DUP_CHK_EN
        dacc_d  = dacc_q;
        dup_d   = dup_q;
`endif
        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    if (bus.in_last) begin
                        // Close the word; accumulators restart clean for the next burst.
                        state_d = EMIT;
                        mask_d  = mask_nxt;
                        cnt_d   = cnt_c;
                        top_d   = top_c;
                        acc_d   = '0;
`ifdef POW_BUILDER_DUP_CHK_EN
                        dup_d   = dacc_q | hit;
                        dacc_d  = 1'b0;
`endif
                    end else begin
                        state_d = ACCUM;
                        acc_d   = mask_nxt;
`ifdef POW_BUILDER_DUP_CHK_EN
                        dacc_d  = dacc_q | hit;
`endif
                    end
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    mask_d  = '0;
                    cnt_d   = '0;
                    top_d   = '0;
`ifdef POW_BUILDER_DUP_CHK_EN
                    dup_d   = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
            top_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            top_q   <= top_d;
        end
    end

`ifdef POW_BUILDER_DUP_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dacc_q <= 1'b0;
            dup_q  <= 1'b0;
        end else begin
            dacc_q <= dacc_d;
            dup_q  <= dup_d;
        end
    end

    assign bus.out_dup = dup_q;
`else
    assign bus.out_dup = 1'b0;
`endif

    assign bus.in_ready  = (state_q != EMIT);
    assign bus.out_valid = (state_q == EMIT);
    assign bus.out_mask  = mask_q;
    assign bus.out_cnt   = cnt_q;
    assign bus.out_top   = top_q;
endmodule

// File: tb/tb_pow_builder.sv
// Directed table, corner sequences and randomized bursts against a queue-based model.
module tb_pow_builder;
    localparam int WIDTH = 8;
`ifdef POW_BUILDER_DUP_CHK_EN
    localparam bit DUP_EN = 1'b1;
`else
    localparam bit DUP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pow_builder_if #(.WIDTH(WIDTH)) bus ();
    pow_builder #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int       n;
        int       idx[4];
        int       gap;
        int       mask;
        int       cnt;
        int       top;
        bit       dup;
    } vec_t;

    function automatic vec_t mk(int n, int i0, int i1, int i2, int i3, int gap,
                                int mask, int cnt, int top, bit dup);
        vec_t v;
        v.n = n; v.idx[0] = i0; v.idx[1] = i1; v.idx[2] = i2; v.idx[3] = i3;
        v.gap = gap; v.mask = mask; v.cnt = cnt; v.top = top; v.dup = dup;
        return v;
    endfunction

    // Drives one beat and returns right after the edge that accepts it.
    task automatic beat(input int idx, input bit last);
        int n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_idx   = 3'(idx);
        bus.in_last  = last;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk("beat_timeout", n, 0);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic check_word(input string tag, input int mask, input int cnt,
                              input int top, input bit dup);
        chk({tag, "_valid"}, int'(bus.out_valid), 1);
        chk({tag, "_inrdy"}, int'(bus.in_ready), 0);
        chk({tag, "_mask"}, int'(bus.out_mask), mask);
        chk({tag, "_cnt"}, int'(bus.out_cnt), cnt);
        chk({tag, "_top"}, int'(bus.out_top), top);
        chk({tag, "_dup"}, int'(bus.out_dup), int'(dup & DUP_EN));
    endtask

    task automatic take(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, "_exit_valid"}, int'(bus.out_valid), 0);
        chk({tag, "_exit_inrdy"}, int'(bus.in_ready), 1);
    endtask

    vec_t vt[5];

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_idx    = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        vt[0] = mk(3, 2, 3, 6, 0, 0, 8'h4C, 3, 6, 1'b0);
        vt[1] = mk(1, 0, 0, 0, 0, 0, 8'h01, 1, 0, 1'b0);
        vt[2] = mk(3, 0, 1, 3, 0, 2, 8'h0B, 3, 3, 1'b0);
        vt[3] = mk(2, 3, 3, 0, 0, 0, 8'h08, 1, 3, 1'b1);
        vt[4] = mk(4, 7, 0, 7, 5, 1, 8'hA1, 3, 7, 1'b1);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_inrdy", int'(bus.in_ready), 1);
        chk("rst_mask", int'(bus.out_mask), 0);
        chk("rst_cnt", int'(bus.out_cnt), 0);
        chk("rst_top", int'(bus.out_top), 0);
        chk("rst_dup", int'(bus.out_dup), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int v = 0; v < 5; v++) begin
            for (int b = 0; b < vt[v].n; b++) begin
                if (b > 0) repeat (vt[v].gap) @(posedge clk);
                beat(vt[v].idx[b], b == vt[v].n - 1);
            end
            check_word($sformatf("vec%0d", v), vt[v].mask, vt[v].cnt, vt[v].top, vt[v].dup);
            take($sformatf("vec%0d", v));
        end

        // Backpressure: in_valid held high during EMIT must not be accepted
        beat(2, 1'b0);
        beat(5, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_idx   = 3'd1;
        bus.in_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check_word($sformatf("bp%0d", c), 8'h24, 2, 5, 1'b0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_exit_valid", int'(bus.out_valid), 0);
        chk("bp_exit_inrdy", int'(bus.in_ready), 1);
        @(negedge clk);
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check_word("bp_next", 8'h02, 1, 1, 1'b0);
        take("bp_next");

        // Reset mid-burst, then reset during EMIT
        beat(5, 1'b0);
        beat(7, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstmid_valid", int'(bus.out_valid), 0);
        chk("rstmid_inrdy", int'(bus.in_ready), 1);
        chk("rstmid_mask", int'(bus.out_mask), 0);
        @(negedge clk);
        rst_n = 1'b1;
        beat(4, 1'b0);
        beat(4, 1'b1);
        chk("pre_rst_valid", int'(bus.out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstemit_valid", int'(bus.out_valid), 0);
        chk("rstemit_mask", int'(bus.out_mask), 0);
        chk("rstemit_cnt", int'(bus.out_cnt), 0);
        chk("rstemit_dup", int'(bus.out_dup), 0);
        @(negedge clk);
        rst_n = 1'b1;
        beat(1, 1'b1);
        check_word("post_rst", 8'h02, 1, 1, 1'b0);
        take("post_rst");

        // Randomized bursts vs. set-of-indices model
        for (int r = 0; r < 40; r++) begin
            int len;
            int seen[$];
            int mmask, mtop, hold;
            bit mdup;
            len   = $urandom_range(1, 6);
            mmask = 0;
            mtop  = 0;
            mdup  = 1'b0;
            seen.delete();
            for (int b = 0; b < len; b++) begin
                int ix;
                int found[$];
                ix = $urandom_range(0, WIDTH - 1);
                found = seen.find(x) with (x == ix);
                if (found.size() > 0) mdup = 1'b1;
                else seen.push_back(ix);
                if (b > 0) repeat ($urandom_range(0, 2)) @(posedge clk);
                beat(ix, b == len - 1);
            end
            foreach (seen[k]) begin
                mmask += (1 << seen[k]);
                if (seen[k] > mtop) mtop = seen[k];
            end
            hold = $urandom_range(0, 3);
            for (int h = 0; h <= hold; h++) begin
                if (h > 0) begin
                    @(posedge clk);
                    #1;
                end
                check_word($sformatf("rnd%0d_h%0d", r, h), mmask, seen.size(), mtop, mdup);
            end
            take($sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/pow_builder.md
# pow_builder

Inverse companion to the priority decoder: rebuilds a WIDTH-bit word from a stream of bit indices. Each index sets one bit of an accumulating mask. The final beat of a burst closes the word, which is then presented through a valid/ready output with its population count and top index. It sits upstream of the priority decoder, so the decoder's result can be round-trip checked against out_top.

## Interface
Parameters:
- WIDTH, 8, width of the rebuilt word; any value ≥ 2.
- IDX_W, $clog2(WIDTH) (3), width of the index input; derived localparam, not overridable.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  index beat valid.
- in_ready  out  1  block accepts a beat.
- in_idx  in  IDX_W  bit index to set.
- in_last  in  1  final beat of the burst.
- out_valid  out  1  rebuilt word available.
- out_ready  in  1  consumer takes the word.
- out_mask  out  WIDTH  rebuilt word.
- out_cnt  out  IDX_W+1  number of set bits in out_mask.
- out_top  out  IDX_W  index of the highest set bit in out_mask; 0 if out_mask is 0.
- out_dup  out  1  a duplicate index was seen in the burst (see Configuration).

## Operation
- FSM states: IDLE, ACCUM, EMIT.
- A beat is accepted when in_valid && in_ready.
- in_ready is 1 in IDLE and ACCUM, and 0 in EMIT.
- Accepted beat: mask |= (1 << in_idx).
  - If in_idx ≥ WIDTH, the beat is accepted but sets no bit.
- Transitions:
  - IDLE→ACCUM on an accepted beat with in_last=0.
  - IDLE→EMIT or ACCUM→EMIT on an accepted beat with in_last=1.
  - ACCUM stays in ACCUM on an accepted beat with in_last=0.
  - EMIT→IDLE on out_valid && out_ready. The mask, count and dup flag clear on the same edge.
- out_valid = (state == EMIT).
- out_mask, out_cnt, out_top and out_dup are registered. They are computed on the edge that accepts the last beat and held stable for the whole of EMIT.
- out_cnt counts distinct bits; duplicate indices count once.
- No beat is accepted in the cycle the output handshake completes. A new burst begins at the earliest one cycle after EMIT exits.
- Gaps (in_valid=0) inside a burst are allowed, with no timeout.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_mask=0, out_cnt=0, out_top=0, out_dup=0.
- rst_n is asserted asynchronously and released synchronously with clk.
- Reset mid-burst or during EMIT discards all partial or pending data. No output handshake is generated.
- Latency: last beat accepted at edge N → out_valid=1 and all outputs valid in the cycle after edge N.
- Single-beat burst (in_last on the first beat): IDLE→EMIT directly, same latency.
- Throughput: a burst of K beats occupies at least K+1 cycles, including one EMIT cycle.
- Backpressure: out_ready low holds EMIT indefinitely with outputs unchanged and in_ready=0.

## Configuration
- Macro POW_BUILDER_DUP_CHK_EN.
- Defined:
  - out_dup is a sticky flag. It sets when an accepted beat targets a bit already set in the current burst, including on the last beat.
  - It is presented with the word and cleared on exit from EMIT or on reset.
- Undefined:
  - out_dup is tied to 0 and no compare logic is built.
  - All other behaviour is identical.

## Test plan
- WIDTH=8; burst 2,3,6 with last on 6 → out_mask=8'b01001100, out_cnt=3, out_top=6, out_valid=1 one cycle after the last beat.
- Single beat 0 with last → out_mask=8'b00000001, out_cnt=1, out_top=0; IDLE→EMIT→IDLE with out_ready=1.
- Burst 0,1,3 with an idle gap of 2 cycles between beats → out_mask=8'b00001011, out_cnt=3, out_top=3.
- Burst 3,3 with last, under POW_BUILDER_DUP_CHK_EN → out_mask=8'h08, out_cnt=1, out_dup=1; without the macro → out_dup=0, all else the same.
- Backpressure: hold out_ready=0 for 5 cycles in EMIT while driving in_valid=1 → in_ready=0, outputs stable, no beat accepted. Raise out_ready → word taken, then the next beat is accepted one cycle later.
- Assert rst_n=0 after beats 5,7 with no last → all outputs return to reset values immediately. The next burst 1 with last → out_mask=8'h02 (no residue from bits 5 and 7).
